balance_manager: RTL and testbench

BALANCE_MANAGER -- requirements
Module: balance_manager

---
 rtl/vm_pkg.sv | 39 +++
 rtl/change_coin_sel.sv | 33 +++
 rtl/balance_manager.sv | 122 ++++++++++++
 tb/tb_balance_manager.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine constants: coin values, item prices, credit ceiling and FSM states.
// All credit quantities are in 100-won units.
package vm_pkg;

    localparam logic [7:0] BAL_MAX   = 8'd255;
    localparam logic [7:0] COIN_100  = 8'd1;
    localparam logic [7:0] COIN_500  = 8'd5;
    localparam logic [7:0] COIN_1000 = 8'd10;
    localparam logic [7:0] COIN_5000 = 8'd50;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RETURN = 1'b1
    } state_t;

    function automatic logic [7:0] item_price(input logic [1:0] sel);
        logic [7:0] price;
        case (sel)
            2'd0:    price = 8'd3;
            2'd1:    price = 8'd5;
            2'd2:    price = 8'd8;
            2'd3:    price = 8'd12;
            default: price = 8'd0;
        endcase
        return price;
    endfunction

    // Total value of every coin pulse present this cycle; never exceeds 66.
    function automatic logic [7:0] coin_sum(input logic [3:0] pulses);
        logic [7:0] sum;
        sum = 8'd0;
        if (pulses[0]) sum = sum + COIN_100;
        if (pulses[1]) sum = sum + COIN_500;
        if (pulses[2]) sum = sum + COIN_1000;
        if (pulses[3]) sum = sum + COIN_5000;
        return sum;
    endfunction

endpackage

// File: rtl/change_coin_sel.sv
// Greedy change selector: picks the largest coin not exceeding the remaining balance.
// Reports the coin one-hot (same bit map as the coin inputs) and its value; zero balance gives no coin.
module change_coin_sel
    import vm_pkg::*;
(
    input  logic [7:0] balance,
    output logic [3:0] coin,
    output logic [7:0] value
);

    // Largest-first comparison chain
    always_comb begin
        coin  = 4'b0000;
        value = 8'd0;
        if (balance >= COIN_5000) begin
            coin  = 4'b1000;
            value = COIN_5000;
        end else if (balance >= COIN_1000) begin
            coin  = 4'b0100;
            value = COIN_1000;
        end else if (balance >= COIN_500) begin
            coin  = 4'b0010;
            value = COIN_500;
        end else if (balance >= COIN_100) begin
            coin  = 4'b0001;
            value = COIN_100;
        end else begin
            coin  = 4'b0000;
            value = 8'd0;
        end
    end

endmodule

// File: rtl/balance_manager.sv
// Vending-machine credit manager: coin acceptance, purchases and greedy change return.
// Every output is registered; pulses appear one cycle after the causing input.
module balance_manager
    import vm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] moneyin_pulse,
    input  logic       buy,
    input  logic [1:0] item_sel,
    input  logic       return_req,
    output logic [7:0] balance,
    output logic [3:0] dispense,
    output logic       buy_fail,
    output logic [3:0] coin_reject,
    output logic [3:0] change_coin,
    output logic       change_done,
    output logic       busy
);

    state_t     state_r, state_s;
    logic [7:0] balance_r, balance_s;
    logic [3:0] dispense_r, dispense_s;
    logic       buy_fail_r, buy_fail_s;
    logic [3:0] coin_reject_r, coin_reject_s;
    logic [3:0] change_coin_r, change_coin_s;
    logic       change_done_r, change_done_s;
    logic       busy_r;

    logic [7:0] price_s;
    logic       buy_ok_s;
    logic [7:0] debit_s;
    logic [7:0] after_debit_s;
    logic [8:0] credit_sum_s;
    logic       coins_ok_s;
    logic [3:0] sel_coin_s;
    logic [7:0] sel_value_s;

    change_coin_sel u_change_coin_sel (
        .balance (balance_r),
        .coin    (sel_coin_s),
        .value   (sel_value_s)
    );

    // Purchase and coin-acceptance arithmetic against the pre-cycle balance
    always_comb begin
        price_s       = item_price(item_sel);
        buy_ok_s      = buy & ~return_req & (balance_r >= price_s);
        debit_s       = buy_ok_s ? price_s : 8'd0;
        after_debit_s = balance_r - debit_s;
        credit_sum_s  = {1'b0, after_debit_s} + {1'b0, coin_sum(moneyin_pulse)};
        coins_ok_s    = (credit_sum_s <= {1'b0, BAL_MAX});
    end

    // Next-state and next-output decode
    always_comb begin
        state_s       = state_r;
        balance_s     = balance_r;
        dispense_s    = 4'b0000;
        buy_fail_s    = 1'b0;
        coin_reject_s = 4'b0000;
        change_coin_s = 4'b0000;
        change_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                balance_s     = coins_ok_s ? credit_sum_s[7:0] : after_debit_s;
                coin_reject_s = coins_ok_s ? 4'b0000 : moneyin_pulse;
                dispense_s    = buy_ok_s ? (4'b0001 << item_sel) : 4'b0000;
                buy_fail_s    = buy & ~buy_ok_s & ~return_req;
                state_s       = return_req ? RETURN : IDLE;
            end
            RETURN: begin
                // Coins are never banked while change is being paid out
                coin_reject_s = moneyin_pulse;
                if (balance_r != 8'd0) begin
                    change_coin_s = sel_coin_s;
                    balance_s     = balance_r - sel_value_s;
                    state_s       = RETURN;
                end else begin
                    change_done_s = 1'b1;
                    state_s       = IDLE;
                end
            end
            default: begin
                state_s   = IDLE;
                balance_s = balance_r;
            end
        endcase
    end

    // State and output registers; reset discards any undelivered change
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            balance_r     <= 8'd0;
            dispense_r    <= 4'b0000;
            buy_fail_r    <= 1'b0;
            coin_reject_r <= 4'b0000;
            change_coin_r <= 4'b0000;
            change_done_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            balance_r     <= balance_s;
            dispense_r    <= dispense_s;
            buy_fail_r    <= buy_fail_s;
            coin_reject_r <= coin_reject_s;
            change_coin_r <= change_coin_s;
            change_done_r <= change_done_s;
            busy_r        <= (state_s == RETURN);
        end
    end

    assign balance     = balance_r;
    assign dispense    = dispense_r;
    assign buy_fail    = buy_fail_r;
    assign coin_reject = coin_reject_r;
    assign change_coin = change_coin_r;
    assign change_done = change_done_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_balance_manager.sv
// Directed bench for balance_manager: coins, purchases, ceiling rejection, change return and reset.
// Expected values are hand-derived from the coin values (1/5/10/50) and prices (3/5/8/12).
module tb_balance_manager;

    logic       clk;
    logic       reset;
    logic [3:0] moneyin_pulse;
    logic       buy;
    logic [1:0] item_sel;
    logic       return_req;
    logic [7:0] balance;
    logic [3:0] dispense;
    logic       buy_fail;
    logic [3:0] coin_reject;
    logic [3:0] change_coin;
    logic       change_done;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int exp_bal;

    balance_manager dut (
        .clk           (clk),
        .reset         (reset),
        .moneyin_pulse (moneyin_pulse),
        .buy           (buy),
        .item_sel      (item_sel),
        .return_req    (return_req),
        .balance       (balance),
        .dispense      (dispense),
        .buy_fail      (buy_fail),
        .coin_reject   (coin_reject),
        .change_coin   (change_coin),
        .change_done   (change_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Compare every output against the hand-computed values
    task automatic expect_all(input string tag, input logic [7:0] e_bal, input logic [3:0] e_disp,
                              input logic e_bf, input logic [3:0] e_crej, input logic [3:0] e_cc,
                              input logic e_cd, input logic e_busy);
        chk({tag, ".balance"},     {24'd0, balance},     {24'd0, e_bal});
        chk({tag, ".dispense"},    {28'd0, dispense},    {28'd0, e_disp});
        chk({tag, ".buy_fail"},    {31'd0, buy_fail},    {31'd0, e_bf});
        chk({tag, ".coin_reject"}, {28'd0, coin_reject}, {28'd0, e_crej});
        chk({tag, ".change_coin"}, {28'd0, change_coin}, {28'd0, e_cc});
        chk({tag, ".change_done"}, {31'd0, change_done}, {31'd0, e_cd});
        chk({tag, ".busy"},        {31'd0, busy},        {31'd0, e_busy});
    endtask

    // Hold the given inputs across one rising edge, then idle them and sample #1 later
    task automatic drive(input logic [3:0] m, input logic b, input logic [1:0] sel,
                         input logic r, input logic rst);
        moneyin_pulse = m;
        buy           = b;
        item_sel      = sel;
        return_req    = r;
        reset         = rst;
        @(posedge clk);
        #1;
        moneyin_pulse = 4'b0000;
        buy           = 1'b0;
        item_sel      = 2'd0;
        return_req    = 1'b0;
        reset         = 1'b0;
    endtask

    initial begin
        moneyin_pulse = 4'b0000;
        buy           = 1'b0;
        item_sel      = 2'd0;
        return_req    = 1'b0;
        reset         = 1'b1;
        #2;

        // Reset wins over a simultaneous coin
        drive(4'b1000, 1'b0, 2'd0, 1'b0, 1'b1);
        expect_all("reset", 8'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        drive(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("coin10", 8'd10, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("coin1", 8'd11, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        drive(4'b0000, 1'b1, 2'd3, 1'b0, 1'b0);
        expect_all("buy3_fail", 8'd11, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
        expect_all("buy2_ok", 8'd3, 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("pulse_end", 8'd3, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Climb to 250: 3 + 4*50 + 4*10 + 5 + 1 + 1
        exp_bal = 3;
        for (int i = 0; i < 4; i++) begin
            drive(4'b1000, 1'b0, 2'd0, 1'b0, 1'b0);
            exp_bal += 50;
        end
        for (int i = 0; i < 4; i++) begin
            drive(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
            exp_bal += 10;
        end
        drive(4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
        exp_bal += 5;
        drive(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        exp_bal += 2;
        chk("climb.balance", {24'd0, balance}, exp_bal);

        drive(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("over_reject", 8'd250, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0);
        drive(4'b0010, 1'b1, 2'd0, 1'b0, 1'b0);
        expect_all("buy_plus_coin", 8'd252, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // 252 - 3 + 10 = 259: coin bounced, purchase still debited
        drive(4'b0100, 1'b1, 2'd0, 1'b0, 1'b0);
        expect_all("buy_coin_rej", 8'd249, 4'b0001, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("exact_max", 8'd255, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("at_max_rej", 8'd255, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);

        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
        expect_all("reset2", 8'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b1111, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("all_coins", 8'd66, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Return 66 = 50 + 10 + 5 + 1
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
        expect_all("ret66_enter", 8'd66, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("ret66_c50", 8'd16, 4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b1);
        drive(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("ret66_c10", 8'd6, 4'b0000, 1'b0, 4'b0001, 4'b0100, 1'b0, 1'b1);
        drive(4'b0000, 1'b1, 2'd0, 1'b1, 1'b0);
        expect_all("ret66_c5", 8'd1, 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("ret66_c1", 8'd0, 4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("ret66_done", 8'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("ret66_idle", 8'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        drive(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 2'd0, 1'b1, 1'b0);
        expect_all("ret20_enter", 8'd20, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("ret20_c10a", 8'd10, 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("ret20_c10b", 8'd0, 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("ret20_done", 8'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);

        // 55 = 50 + 5 in one cycle, then reset right after entering RETURN
        drive(4'b1010, 1'b0, 2'd0, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
        expect_all("ret55_enter", 8'd55, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
        expect_all("ret55_reset", 8'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_all("ret55_after", 8'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
